reservation_station: RTL and testbench

- Reservation station directly upstream of the functional unit in the Tomasulo datapath.
- Holds up to DEPTH issued add/sub/ld/sd instructions until both operands are valid.
- Captures missing operands by snooping the common data bus (CDB).
- Dispatches one ready entry at a time to the functional unit as a one-cycle instructIn pulse carrying the instruction, its 3-bit tag and both operand values.

---
 rtl/tomasulo_pkg.sv | 26 ++
 rtl/rs_entry.sv | 85 ++++++++
 rtl/reservation_station.sv | 150 +++++++++++++++
 tb/tb_reservation_station.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo datapath blocks.
// Provides tag/data widths, the "no producer" tag value, the opcodes the
// functional unit distinguishes, and the reservation-station entry record.
package tomasulo_pkg;

  localparam int TAG_W   = 3;
  localparam int DATA_W  = 16;
  localparam int INSTR_W = 16;

  // A Q field equal to TAG_NONE means the matching V field already holds the value.
  localparam logic [TAG_W-1:0] TAG_NONE = 3'b000;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;

  typedef struct packed {
    logic               busy;
    logic [INSTR_W-1:0] instr;
    logic [TAG_W-1:0]   tag;
    logic [DATA_W-1:0]  vj;
    logic [TAG_W-1:0]   qj;
    logic [DATA_W-1:0]  vk;
    logic [TAG_W-1:0]   qk;
  } rs_entry_t;

endpackage

// File: rtl/rs_entry.sv
// One reservation-station entry.
// Holds an issued instruction with its two operands, captures operands from
// the CDB (both in the issue cycle and while waiting) and flags readiness.
// Ports:
//   clock, resetn        clock and synchronous active-low reset
//   i_we                 write a newly issued instruction into this entry
//   i_instr/i_tag        instruction word and its tag
//   i_vj/i_qj, i_vk/i_qk operand values and producer tags at issue
//   i_cdb_valid/_tag/_data  common data bus broadcast
//   i_clear              entry dispatched this edge; release it
//   o_busy, o_ready      entry occupied / occupied with both operands valid
//   o_instr, o_tag, o_vj, o_vk  stored fields for the dispatch mux
import tomasulo_pkg::*;

module rs_entry (
  input  logic               clock,
  input  logic               resetn,
  input  logic               i_we,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [TAG_W-1:0]   i_tag,
  input  logic [DATA_W-1:0]  i_vj,
  input  logic [TAG_W-1:0]   i_qj,
  input  logic [DATA_W-1:0]  i_vk,
  input  logic [TAG_W-1:0]   i_qk,
  input  logic               i_cdb_valid,
  input  logic [TAG_W-1:0]   i_cdb_tag,
  input  logic [DATA_W-1:0]  i_cdb_data,
  input  logic               i_clear,
  output logic               o_busy,
  output logic               o_ready,
  output logic [INSTR_W-1:0] o_instr,
  output logic [TAG_W-1:0]   o_tag,
  output logic [DATA_W-1:0]  o_vj,
  output logic [DATA_W-1:0]  o_vk
);

  rs_entry_t r_entry;

  logic w_bypass_j, w_bypass_k;
  logic w_snoop_j, w_snoop_k;

  // The Q != TAG_NONE guard keeps an already-valid operand from being
  // overwritten by a broadcast that happens to carry tag 0.
  assign w_bypass_j = i_cdb_valid && (i_qj != TAG_NONE) && (i_qj == i_cdb_tag);
  assign w_bypass_k = i_cdb_valid && (i_qk != TAG_NONE) && (i_qk == i_cdb_tag);
  assign w_snoop_j  = i_cdb_valid && (r_entry.qj != TAG_NONE) && (r_entry.qj == i_cdb_tag);
  assign w_snoop_k  = i_cdb_valid && (r_entry.qk != TAG_NONE) && (r_entry.qk == i_cdb_tag);

  // Issue only targets a free entry and dispatch only a busy one, so
  // i_we and i_clear never coincide.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_entry <= '0;
    end else if (i_we) begin
      r_entry.busy  <= 1'b1;
      r_entry.instr <= i_instr;
      r_entry.tag   <= i_tag;
      r_entry.vj    <= w_bypass_j ? i_cdb_data : i_vj;
      r_entry.qj    <= w_bypass_j ? TAG_NONE   : i_qj;
      r_entry.vk    <= w_bypass_k ? i_cdb_data : i_vk;
      r_entry.qk    <= w_bypass_k ? TAG_NONE   : i_qk;
    end else if (i_clear) begin
      r_entry.busy <= 1'b0;
    end else if (r_entry.busy) begin
      if (w_snoop_j) begin
        r_entry.vj <= i_cdb_data;
        r_entry.qj <= TAG_NONE;
      end
      if (w_snoop_k) begin
        r_entry.vk <= i_cdb_data;
        r_entry.qk <= TAG_NONE;
      end
    end
  end

  // Readiness comes from registered Q fields only, so a CDB capture
  // becomes dispatchable one edge later.
  assign o_ready = r_entry.busy && (r_entry.qj == TAG_NONE) && (r_entry.qk == TAG_NONE);
  assign o_busy  = r_entry.busy;
  assign o_instr = r_entry.instr;
  assign o_tag   = r_entry.tag;
  assign o_vj    = r_entry.vj;
  assign o_vk    = r_entry.vk;

endmodule

// File: rtl/reservation_station.sv
// Reservation station feeding a single functional unit.
// Accepts issued instructions into the lowest free entry, waits for both
// operands (snooping the CDB), and dispatches the lowest ready entry as a
// one-cycle instructIn pulse whenever the functional unit is idle.
// Ports:
//   clock, resetn                 clock and synchronous active-low reset
//   issueValid/Instruction/Tag    issue request
//   issueVj/Vk, issueQj/Qk        operands and producer tags
//   issueReady                    at least one free entry
//   cdbValid/cdbTag/cdbData       common data bus broadcast
//   fuDone                        functional unit finished
//   instructIn                    one-cycle dispatch pulse
//   instruction, instructionCodeOut, reg1, reg2  dispatched fields
//   occupancy                     number of busy entries
import tomasulo_pkg::*;

module reservation_station #(
  parameter int DEPTH = 3,
  parameter int CNT_W = 2
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               issueValid,
  input  logic [INSTR_W-1:0] issueInstruction,
  input  logic [TAG_W-1:0]   issueTag,
  input  logic [DATA_W-1:0]  issueVj,
  input  logic [DATA_W-1:0]  issueVk,
  input  logic [TAG_W-1:0]   issueQj,
  input  logic [TAG_W-1:0]   issueQk,
  output logic               issueReady,
  input  logic               cdbValid,
  input  logic [TAG_W-1:0]   cdbTag,
  input  logic [DATA_W-1:0]  cdbData,
  input  logic               fuDone,
  output logic [INSTR_W-1:0] instruction,
  output logic               instructIn,
  output logic [TAG_W-1:0]   instructionCodeOut,
  output logic [DATA_W-1:0]  reg1,
  output logic [DATA_W-1:0]  reg2,
  output logic [CNT_W-1:0]   occupancy
);

  logic [DEPTH-1:0]   w_busy, w_ready, w_free_oh, w_ready_oh, w_issue_we, w_clear;
  logic [INSTR_W-1:0] w_instr [DEPTH];
  logic [TAG_W-1:0]   w_tag   [DEPTH];
  logic [DATA_W-1:0]  w_vj    [DEPTH];
  logic [DATA_W-1:0]  w_vk    [DEPTH];
  logic               w_accept, w_dispatch;
  logic [INSTR_W-1:0] w_sel_instr;
  logic [TAG_W-1:0]   w_sel_tag;
  logic [DATA_W-1:0]  w_sel_vj, w_sel_vk;

  logic               r_fu_busy, r_dispatch_pending, r_instruct_in;
  logic [INSTR_W-1:0] r_instruction;
  logic [TAG_W-1:0]   r_code;
  logic [DATA_W-1:0]  r_reg1, r_reg2;
  logic [CNT_W-1:0]   r_occupancy;

  // Lowest-index one-hot picks: lowest clear bit of busy, lowest set bit of ready.
  assign w_free_oh  = ~w_busy & (w_busy + DEPTH'(1));
  assign w_ready_oh = w_ready & (~w_ready + DEPTH'(1));

  assign issueReady = ~&w_busy;
  assign w_accept   = issueValid && issueReady && (issueTag != TAG_NONE);
  assign w_dispatch = !r_fu_busy && (|w_ready);
  assign w_issue_we = {DEPTH{w_accept}} & w_free_oh;
  assign w_clear    = {DEPTH{w_dispatch}} & w_ready_oh;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      rs_entry u_entry (
        .clock      (clock),
        .resetn     (resetn),
        .i_we       (w_issue_we[gi]),
        .i_instr    (issueInstruction),
        .i_tag      (issueTag),
        .i_vj       (issueVj),
        .i_qj       (issueQj),
        .i_vk       (issueVk),
        .i_qk       (issueQk),
        .i_cdb_valid(cdbValid),
        .i_cdb_tag  (cdbTag),
        .i_cdb_data (cdbData),
        .i_clear    (w_clear[gi]),
        .o_busy     (w_busy[gi]),
        .o_ready    (w_ready[gi]),
        .o_instr    (w_instr[gi]),
        .o_tag      (w_tag[gi]),
        .o_vj       (w_vj[gi]),
        .o_vk       (w_vk[gi])
      );
    end
  endgenerate

  always_comb begin
    w_sel_instr = '0;
    w_sel_tag   = '0;
    w_sel_vj    = '0;
    w_sel_vk    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ready_oh[i]) begin
        w_sel_instr = w_instr[i];
        w_sel_tag   = w_tag[i];
        w_sel_vj    = w_vj[i];
        w_sel_vk    = w_vk[i];
      end
    end
  end

  // The FU sees instructIn one cycle late, so a fuDone during the cycle right
  // after dispatch still refers to the previous operation and is ignored.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_fu_busy          <= 1'b0;
      r_dispatch_pending <= 1'b0;
      r_instruct_in      <= 1'b0;
      r_instruction      <= '0;
      r_code             <= '0;
      r_reg1             <= '0;
      r_reg2             <= '0;
      r_occupancy        <= '0;
    end else begin
      r_dispatch_pending <= w_dispatch;
      r_instruct_in      <= w_dispatch;
      if (w_dispatch) begin
        r_fu_busy     <= 1'b1;
        r_instruction <= w_sel_instr;
        r_code        <= w_sel_tag;
        r_reg1        <= w_sel_vj;
        r_reg2        <= w_sel_vk;
      end else if (r_fu_busy && !r_dispatch_pending && fuDone) begin
        r_fu_busy <= 1'b0;
      end
      case ({w_accept, w_dispatch})
        2'b10:   r_occupancy <= r_occupancy + CNT_W'(1);
        2'b01:   r_occupancy <= r_occupancy - CNT_W'(1);
        default: r_occupancy <= r_occupancy;
      endcase
    end
  end

  assign instructIn         = r_instruct_in;
  assign instruction        = r_instruction;
  assign instructionCodeOut = r_code;
  assign reg1               = r_reg1;
  assign reg2               = r_reg2;
  assign occupancy          = r_occupancy;

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed scenarios followed by
// random traffic, all compared against a behavioural model of the station.
module tb_reservation_station;

  localparam int DEPTH = 3;
  localparam int CNT_W = 2;

  logic        clock;
  logic        resetn;
  logic        issueValid;
  logic [15:0] issueInstruction;
  logic [2:0]  issueTag;
  logic [15:0] issueVj, issueVk;
  logic [2:0]  issueQj, issueQk;
  logic        issueReady;
  logic        cdbValid;
  logic [2:0]  cdbTag;
  logic [15:0] cdbData;
  logic        fuDone;
  logic [15:0] instruction;
  logic        instructIn;
  logic [2:0]  instructionCodeOut;
  logic [15:0] reg1, reg2;
  logic [CNT_W-1:0] occupancy;

  reservation_station #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .resetn(resetn),
    .issueValid(issueValid), .issueInstruction(issueInstruction), .issueTag(issueTag),
    .issueVj(issueVj), .issueVk(issueVk), .issueQj(issueQj), .issueQk(issueQk),
    .issueReady(issueReady),
    .cdbValid(cdbValid), .cdbTag(cdbTag), .cdbData(cdbData),
    .fuDone(fuDone),
    .instruction(instruction), .instructIn(instructIn),
    .instructionCodeOut(instructionCodeOut), .reg1(reg1), .reg2(reg2),
    .occupancy(occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int    vectors = 0;
  int    miscompares = 0;
  string phase = "init";

  // Behavioural model: a table of pending instructions plus FU state.
  bit          m_busy  [DEPTH];
  logic [15:0] m_instr [DEPTH];
  logic [2:0]  m_tag   [DEPTH];
  logic [15:0] m_vj    [DEPTH];
  logic [2:0]  m_qj    [DEPTH];
  logic [15:0] m_vk    [DEPTH];
  logic [2:0]  m_qk    [DEPTH];
  bit          m_fu_busy, m_just_sent;
  logic        e_ii;
  logic [15:0] e_instr, e_r1, e_r2;
  logic [2:0]  e_code;

  function automatic int count_busy();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  task automatic model_step();
    int rdy = -1;
    int fr  = -1;
    bit disp, acc;
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
      m_fu_busy = 0; m_just_sent = 0;
      e_ii = 0; e_instr = 0; e_code = 0; e_r1 = 0; e_r2 = 0;
      return;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy < 0 && m_busy[i] && m_qj[i] == 0 && m_qk[i] == 0) rdy = i;
      if (fr < 0 && !m_busy[i]) fr = i;
    end
    disp = !m_fu_busy && (rdy >= 0);
    acc  = issueValid && (fr >= 0) && (issueTag != 0);
    if (disp) m_fu_busy = 1;
    else if (m_fu_busy && !m_just_sent && fuDone) m_fu_busy = 0;
    m_just_sent = disp;
    e_ii = disp;
    if (disp) begin
      e_instr = m_instr[rdy]; e_code = m_tag[rdy];
      e_r1 = m_vj[rdy]; e_r2 = m_vk[rdy];
      m_busy[rdy] = 0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (m_busy[i] && cdbValid) begin
        if (m_qj[i] != 0 && m_qj[i] == cdbTag) begin m_vj[i] = cdbData; m_qj[i] = 0; end
        if (m_qk[i] != 0 && m_qk[i] == cdbTag) begin m_vk[i] = cdbData; m_qk[i] = 0; end
      end
    end
    if (acc) begin
      m_busy[fr] = 1; m_instr[fr] = issueInstruction; m_tag[fr] = issueTag;
      m_vj[fr] = issueVj; m_qj[fr] = issueQj; m_vk[fr] = issueVk; m_qk[fr] = issueQk;
      if (cdbValid && issueQj != 0 && issueQj == cdbTag) begin m_vj[fr] = cdbData; m_qj[fr] = 0; end
      if (cdbValid && issueQk != 0 && issueQk == cdbTag) begin m_vk[fr] = cdbData; m_qk[fr] = 0; end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", phase, name, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("instructIn", 32'(instructIn), 32'(e_ii));
    chk("instruction", 32'(instruction), 32'(e_instr));
    chk("code", 32'(instructionCodeOut), 32'(e_code));
    chk("reg1", 32'(reg1), 32'(e_r1));
    chk("reg2", 32'(reg2), 32'(e_r2));
    chk("occupancy", 32'(occupancy), 32'(count_busy()));
    chk("issueReady", 32'(issueReady), 32'(count_busy() < DEPTH));
  endtask

  // Model the edge with the inputs currently applied, then compare #1 after it.
  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic drive_issue(input logic [15:0] instr, input logic [2:0] tag,
                             input logic [15:0] vj, input logic [2:0] qj,
                             input logic [15:0] vk, input logic [2:0] qk);
    issueValid = 1'b1; issueInstruction = instr; issueTag = tag;
    issueVj = vj; issueQj = qj; issueVk = vk; issueQk = qk;
  endtask

  initial begin
    resetn = 1'b0; issueValid = 1'b0; issueInstruction = '0; issueTag = '0;
    issueVj = '0; issueVk = '0; issueQj = '0; issueQk = '0;
    cdbValid = 1'b0; cdbTag = '0; cdbData = '0; fuDone = 1'b0;
    e_ii = 0; e_instr = 0; e_code = 0; e_r1 = 0; e_r2 = 0;
    m_fu_busy = 0; m_just_sent = 0;
    for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;

    phase = "reset";
    tick();
    chk("rst_ready", 32'(issueReady), 32'd1);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_ii", 32'(instructIn), 32'd0);
    resetn = 1'b1;

    phase = "ready_add";
    drive_issue(16'h0000, 3'd1, 16'd5, 3'd0, 16'd3, 3'd0);
    tick();
    chk("occ_after_issue", 32'(occupancy), 32'd1);
    chk("no_early_dispatch", 32'(instructIn), 32'd0);
    issueValid = 1'b0;
    tick();
    chk("dispatch", 32'(instructIn), 32'd1);
    chk("reg1", 32'(reg1), 32'd5);
    chk("reg2", 32'(reg2), 32'd3);
    chk("code", 32'(instructionCodeOut), 32'd1);
    chk("occ_after_dispatch", 32'(occupancy), 32'd0);
    tick();
    chk("pulse_one_cycle", 32'(instructIn), 32'd0);
    fuDone = 1'b1; tick(); fuDone = 1'b0;

    phase = "cdb_wait";
    drive_issue(16'h0001, 3'd2, 16'hdead, 3'd4, 16'd10, 3'd0);
    tick();
    issueValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("held", 32'(instructIn), 32'd0);
    end
    cdbValid = 1'b1; cdbTag = 3'd4; cdbData = 16'h0007;
    tick();
    chk("no_same_edge", 32'(instructIn), 32'd0);
    cdbValid = 1'b0;
    tick();
    chk("dispatch", 32'(instructIn), 32'd1);
    chk("reg1", 32'(reg1), 32'd7);
    chk("reg2", 32'(reg2), 32'd10);
    chk("code", 32'(instructionCodeOut), 32'd2);
    tick();
    fuDone = 1'b1; tick(); fuDone = 1'b0;

    phase = "bypass";
    drive_issue(16'h0003, 3'd3, 16'hbeef, 3'd5, 16'd1, 3'd0);
    cdbValid = 1'b1; cdbTag = 3'd5; cdbData = 16'd9;
    tick();
    issueValid = 1'b0; cdbValid = 1'b0;
    tick();
    chk("dispatch", 32'(instructIn), 32'd1);
    chk("reg1", 32'(reg1), 32'd9);
    chk("code", 32'(instructionCodeOut), 32'd3);

    // FU stays busy with the bypass instruction while the station fills.
    phase = "fill";
    drive_issue(16'h0000, 3'd1, 16'd11, 3'd0, 16'd21, 3'd0); tick();
    drive_issue(16'h0001, 3'd2, 16'd12, 3'd0, 16'd22, 3'd0); tick();
    drive_issue(16'h0002, 3'd3, 16'd13, 3'd0, 16'd23, 3'd0); tick();
    chk("full_occ", 32'(occupancy), 32'd3);
    chk("full_ready", 32'(issueReady), 32'd0);
    drive_issue(16'h0000, 3'd4, 16'd14, 3'd0, 16'd24, 3'd0); tick();
    chk("drop_occ", 32'(occupancy), 32'd3);
    issueValid = 1'b0;
    fuDone = 1'b1; tick(); fuDone = 1'b0;
    tick();
    chk("first_code", 32'(instructionCodeOut), 32'd1);
    chk("first_reg1", 32'(reg1), 32'd11);
    fuDone = 1'b1; tick(); fuDone = 1'b0;
    tick();
    chk("early_done_ignored", 32'(instructIn), 32'd0);
    fuDone = 1'b1; tick(); fuDone = 1'b0;
    tick();
    chk("second_code", 32'(instructionCodeOut), 32'd2);
    chk("second_reg1", 32'(reg1), 32'd12);
    tick();
    fuDone = 1'b1; tick(); fuDone = 1'b0;
    tick();
    chk("third_code", 32'(instructionCodeOut), 32'd3);
    chk("third_ii", 32'(instructIn), 32'd1);
    chk("third_occ", 32'(occupancy), 32'd0);

    phase = "mid_reset";
    drive_issue(16'h0000, 3'd5, 16'd1, 3'd0, 16'd2, 3'd0); tick();
    drive_issue(16'h0000, 3'd6, 16'd3, 3'd0, 16'd4, 3'd0); tick();
    chk("two_busy", 32'(occupancy), 32'd2);
    issueValid = 1'b0;
    resetn = 1'b0; tick(); resetn = 1'b1;
    chk("occ", 32'(occupancy), 32'd0);
    chk("ii", 32'(instructIn), 32'd0);
    chk("ready", 32'(issueReady), 32'd1);
    fuDone = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_stale_dispatch", 32'(instructIn), 32'd0);
    end
    fuDone = 1'b0;

    phase = "random";
    for (int n = 0; n < 600; n++) begin
      resetn = ($urandom_range(0, 99) != 0);
      issueValid = $urandom_range(0, 1);
      issueInstruction = 16'($urandom);
      issueTag = 3'($urandom_range(0, 7));
      issueVj = 16'($urandom);
      issueVk = 16'($urandom);
      issueQj = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      issueQk = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      cdbValid = ($urandom_range(0, 2) == 0);
      cdbTag = 3'($urandom_range(1, 7));
      cdbData = 16'($urandom);
      fuDone = $urandom_range(0, 1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
